ddr2_wr_arbiter: RTL
====================

// Module: ddr2_wr_arbiter
// PURPOSE
//  Shares the single DDR2 write port (address FIFO af_*, write-data FIFO wdf_*) between two
//  burst writers: r0 = frame filler, r1 = line/pixel engine. Each writer keeps its own
//  unmodified af/wdf protocol. A writer that does not hold the grant sees its full flags
//  forced high. A burst is 1 af entry + 2 wdf beats of 128b, and is never split across grants.
// PARAMETERS
//  MAX_BURSTS  4   bursts a grantee may issue back-to-back before a forced re-arbitration (1..15)
// PORTS
//  clk           in   1    system clock
//  rst           in   1    synchronous, active-high reset
//  rN_af_addr_din in  31   requester N (N=0,1) burst address
//  rN_af_wr_en   in   1    requester N address write (marks beat 1 of a burst)
//  rN_wdf_din    in   128  requester N write data
//  rN_wdf_mask_din in 16   requester N byte mask (1 = masked)
//  rN_wdf_wr_en  in   1    requester N data write
//  rN_af_full    out  1    af_full as seen by N; forced 1 when not granted or in BEAT2
//  rN_wdf_full   out  1    wdf_full as seen by N; forced 1 when not granted
//  af_full       in   1    DDR2 address FIFO full
//  wdf_full      in   1    DDR2 write-data FIFO full
//  af_addr_din   out  31   muxed address
//  af_wr_en      out  1    address FIFO write
//  wdf_din       out  128  muxed data
//  wdf_mask_din  out  16   muxed mask; 16'hffff when no data write
//  wdf_wr_en     out  1    data FIFO write
//  grant         out  2    one-hot registered grant; 2'b00 = none
//  busy          out  1    state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, grant=00, rr_last=1 (r0 wins first tie), burst_cnt=0,
//   af_wr_en=wdf_wr_en=0, wdf_mask_din=16'hffff, all rN_*_full=1.
//  req_N = rN_af_wr_en. No combinational path from any rN_* input to any rN_*_full output,
//   because the grant is registered.
//  IDLE: if req_0|req_1, pick the winner by round-robin against rr_last and register grant.
//   Go to GRANT. Arbitration costs 1 cycle; no FIFO write happens in IDLE.
//  GRANT (beat 1): granted requester sees the true af_full/wdf_full.
//   beat1_ok = g_af_wr_en & g_wdf_wr_en & !af_full & !wdf_full.
//   When beat1_ok: af_wr_en=1 and wdf_wr_en=1 in the same cycle, then go to BEAT2.
//   A lone g_wdf_wr_en without g_af_wr_en is dropped (protocol violation).
//   If !g_af_wr_en in GRANT, the grantee is done: set rr_last=grantee, grant=00, go to IDLE.
//  BEAT2: rG_af_full forced 1; af_wr_en=0.
//   beat2_ok = g_wdf_wr_en & !wdf_full sets wdf_wr_en=1 and increments burst_cnt.
//   If burst_cnt+1==MAX_BURSTS and the other requester is requesting: release (rr_last=grantee,
//    burst_cnt=0, IDLE). Otherwise return to GRANT.
//   Stall indefinitely while the beat is not accepted; no timeout.
//  Outputs to DDR are combinational muxes of the granted inputs, gated by state and the full flags.
//   The arbiter never writes a full FIFO.
//  af_full and wdf_full rising mid-burst: hold state; the burst resumes when they clear.
//  Simultaneous req_0 & req_1 in IDLE: the requester != rr_last wins.
//  rst mid-burst: abort immediately to reset values. The partial DDR burst is the caller's concern.
//  Release at MAX_BURSTS occurs only on a burst boundary, never between BEAT1 and BEAT2.
// CONFIGURATION
//  WR_ARB_PERF_CNT_EN defined: adds outputs perf_r0_bursts[31:0], perf_r1_bursts[31:0]
//   and perf_stall[31:0].
//   perf_rN_bursts increments on each beat2_ok of requester N.
//   perf_stall counts cycles in GRANT/BEAT2 with a pending write blocked by full.
//   All counters clear on rst and wrap at 2^32.
//  Undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package ddr2_wr_arb_pkg holds: state encoding IDLE=2'd0, GRANT=2'd1, BEAT2=2'd2;
//   AF_ADDR_W=31, WDF_W=128, MASK_W=16; MASK_NONE=16'hffff.
//  Sub-module rr_pick2: combinational 2-way round-robin picker (req[1:0], last -> gnt[1:0]).
//  Top holds the FSM, grant/rr_last/burst_cnt registers, the datapath muxes and the optional counters.
// TESTING
//  1 Only r0 issues 3 bursts, FIFOs never full -> grant=01 after 1 cycle; af_wr_en pulses 3x;
//    wdf_wr_en 6x; r1_*_full held 1.
//  2 r0 & r1 both request continuously, MAX_BURSTS=4 -> grant sequence 01,10,01;
//    each tenure is exactly 4 bursts (8 wdf beats); no beat is interleaved.
//  3 wdf_full=1 for 5 cycles while in BEAT2 -> wdf_wr_en stays 0, state holds;
//    the second beat is written on the first cycle wdf_full=0; grant unchanged.
//  4 r0 asserts r0_wdf_wr_en without r0_af_wr_en in GRANT -> wdf_wr_en=0, state stays GRANT.
//  5 rst pulsed during BEAT2 of r1 -> next cycle grant=00, af/wdf_wr_en=0, mask=16'hffff;
//    after release r0 wins the simultaneous request.
//  6 WR_ARB_PERF_CNT_EN defined, 2 r0 + 1 r1 bursts, 3 blocked cycles ->
//    perf_r0_bursts=2, perf_r1_bursts=1, perf_stall=3.

Source files
------------

// File: rtl/ddr2_wr_arb_pkg.sv
// Shared types and widths for the two-writer DDR2 write-port arbiter.
package ddr2_wr_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BEAT2 = 2'd2
  } arb_state_e;

  localparam int AF_ADDR_W = 31;
  localparam int WDF_W     = 128;
  localparam int MASK_W    = 16;
  localparam logic [MASK_W-1:0] MASK_NONE = 16'hffff;
endpackage

// File: rtl/ddr2_wr_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not go last wins.
module rr_pick2
  import ddr2_wr_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/ddr2_wr_arbiter.sv
// Shares the DDR2 af/wdf write port between two burst writers, whole bursts only.
// Optional WR_ARB_PERF_CNT_EN adds burst and stall performance counters.
module ddr2_wr_arbiter
  import ddr2_wr_arb_pkg::*;
#(
  parameter int MAX_BURSTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef WR_ARB_PERF_CNT_EN
  output logic [31:0]          perf_r0_bursts,
  output logic [31:0]          perf_r1_bursts,
  output logic [31:0]          perf_stall,
`endif
  input  logic [AF_ADDR_W-1:0] r0_af_addr_din,
  input  logic                 r0_af_wr_en,
  input  logic [WDF_W-1:0]     r0_wdf_din,
  input  logic [MASK_W-1:0]    r0_wdf_mask_din,
  input  logic                 r0_wdf_wr_en,
  output logic                 r0_af_full,
  output logic                 r0_wdf_full,
  input  logic [AF_ADDR_W-1:0] r1_af_addr_din,
  input  logic                 r1_af_wr_en,
  input  logic [WDF_W-1:0]     r1_wdf_din,
  input  logic [MASK_W-1:0]    r1_wdf_mask_din,
  input  logic                 r1_wdf_wr_en,
  output logic                 r1_af_full,
  output logic                 r1_wdf_full,
  input  logic                 af_full,
  input  logic                 wdf_full,
  output logic [AF_ADDR_W-1:0] af_addr_din,
  output logic                 af_wr_en,
  output logic [WDF_W-1:0]     wdf_din,
  output logic [MASK_W-1:0]    wdf_mask_din,
  output logic                 wdf_wr_en,
  output logic [1:0]           grant,
  output logic                 busy
);
  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_last_q, rr_last_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;

  logic [1:0] req, pick;
  logic       g_af_en, g_wdf_en, other_req, beat1_ok, beat2_ok, limit_hit;
  logic [MASK_W-1:0] g_mask;

  assign req = {r1_af_wr_en, r0_af_wr_en};

  rr_pick2 u_pick (.req_i(req), .last_i(rr_last_q), .gnt_o(pick));

  assign g_af_en   = |(grant_q & req);
  assign g_wdf_en  = |(grant_q & {r1_wdf_wr_en, r0_wdf_wr_en});
  assign other_req = |(~grant_q & req);
  assign beat1_ok  = (state_q == GRANT) && g_af_en && g_wdf_en && !af_full && !wdf_full;
  assign beat2_ok  = (state_q == BEAT2) && g_wdf_en && !wdf_full;
  assign limit_hit = ({1'b0, burst_cnt_q} + 5'd1) >= 5'(MAX_BURSTS);

  assign af_addr_din  = grant_q[1] ? r1_af_addr_din : r0_af_addr_din;
  assign wdf_din      = grant_q[1] ? r1_wdf_din : r0_wdf_din;
  assign g_mask       = grant_q[1] ? r1_wdf_mask_din : r0_wdf_mask_din;
  assign wdf_mask_din = wdf_wr_en ? g_mask : MASK_NONE;

  // Full flags depend only on registered grant/state plus the DDR flags.
  assign r0_af_full  = !(grant_q[0] && state_q == GRANT) || af_full;
  assign r1_af_full  = !(grant_q[1] && state_q == GRANT) || af_full;
  assign r0_wdf_full = !grant_q[0] || wdf_full;
  assign r1_wdf_full = !grant_q[1] || wdf_full;

  assign grant = grant_q;
  assign busy  = state_q != IDLE;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    af_wr_en    = 1'b0;
    wdf_wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (beat1_ok) begin
          af_wr_en  = 1'b1;
          wdf_wr_en = 1'b1;
          state_d   = BEAT2;
        end else if (!g_af_en && !g_wdf_en) begin
          // A lone data write keeps the tenure open but is never forwarded.
          rr_last_d   = grant_q[1];
          grant_d     = 2'b00;
          burst_cnt_d = 4'd0;
          state_d     = IDLE;
        end
      end
      BEAT2: begin
        if (beat2_ok) begin
          wdf_wr_en = 1'b1;
          if (limit_hit && other_req) begin
            rr_last_d   = grant_q[1];
            grant_d     = 2'b00;
            burst_cnt_d = 4'd0;
            state_d     = IDLE;
          end else begin
            // Saturate so the limit still applies if the rival shows up late.
            burst_cnt_d = limit_hit ? 4'(MAX_BURSTS) : burst_cnt_q + 4'd1;
            state_d     = GRANT;
          end
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      rr_last_q   <= 1'b1;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef WR_ARB_PERF_CNT_EN
  logic [31:0] perf_r0_q, perf_r1_q, perf_stall_q;
  logic        stall;

  assign stall = ((state_q == GRANT) && g_af_en && (af_full || wdf_full)) ||
                 ((state_q == BEAT2) && g_wdf_en && wdf_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_r0_q    <= 32'd0;
      perf_r1_q    <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_r0_q    <= perf_r0_q + 32'(beat2_ok && grant_q[0]);
      perf_r1_q    <= perf_r1_q + 32'(beat2_ok && grant_q[1]);
      perf_stall_q <= perf_stall_q + 32'(stall);
    end
  end

  assign perf_r0_bursts = perf_r0_q;
  assign perf_r1_bursts = perf_r1_q;
  assign perf_stall     = perf_stall_q;
`endif
endmodule
